pe_seq_controller: RTL
======================

PE_SEQ_CONTROLLER -- requirements
Module: pe_seq_controller

Interface
REQ-001 SHALL have parameters (name, default, meaning): INST_W 16 instruction width; DATA_LEN 32 lane width; IRAM_DEPTH 256 instruction words; DRAM_DEPTH 256 data words; WAIT_TIMEOUT 64 max wait cycles.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk in 1: single clock.
- rst in 1: synchronous, active-high reset.
- start in 1: run pulse.
- step_en in 1: single-step mode.
- step in 1: step pulse.
- imem_addr out 8: instruction address.
- imem_rdata in 16: instruction, valid one cycle after imem_addr.
- dmem_a_rd out 1, dmem_a_addr out 8: operand-A read.
- dmem_b_rd out 1, dmem_b_addr out 8: operand-B read.
- pe_issue out 1, pe_opcode out 3: PE operation strobe and code.
- pe_stage_1_valid in 1, pe_stage_2_valid in 1: PE stage results ready.
- store_temp_s1 out 1, store_temp_s2 out 1: temp-store strobes.
- store_result out 1, res_addr out 8: result-store strobe and address.
- busy out 1, done out 1, err out 1: status.
- err_code out 2: 1 illegal opcode, 2 wait timeout, 3 pc overrun.
- pc out 8: current program counter.

Function
REQ-003 Instruction format SHALL be [15:12] reserved, [11:4] operand address, [3:0] opcode: 0 NOOP, 1 FETCH_A, 2 FETCH_B, 3 ADD, 4 SUB, 5 MUL, 6 DOTP, 7 STORE_TEMP_S1, 8 STORE_TEMP_S2, 9 STORE_RESULT, 10 STOP, 11-15 illegal.
REQ-004 FSM states SHALL be IDLE, FETCH, DECODE, WAIT_S1, WAIT_S2, WAIT_RES, HALT, ERR.
REQ-005 In IDLE or HALT, start=1 SHALL set pc=0 and go to FETCH; start in any other state SHALL be ignored.
REQ-006 In FETCH, imem_addr=pc; with step_en=1, FETCH SHALL hold until step=1; otherwise it SHALL go to DECODE next cycle.
REQ-007 In DECODE, imem_rdata SHALL be decoded and all strobes SHALL be asserted for exactly that one cycle.
REQ-008 NOOP: no strobe; pc+1; go to FETCH. Cost is 2 cycles per instruction.
REQ-009 FETCH_A / FETCH_B: dmem_a_rd / dmem_b_rd=1 with addr=operand; pc+1; go to FETCH.
REQ-010 ADD/SUB/MUL/DOTP: pe_issue=1, pe_opcode=1/2/3/4 respectively (0 otherwise); pc+1; go to FETCH.
REQ-011 STORE_TEMP_S1 SHALL go to WAIT_S1; STORE_TEMP_S2 SHALL go to WAIT_S2; STORE_RESULT SHALL go to WAIT_RES and latch operand into res_addr.
REQ-012 WAIT_S1/WAIT_S2: on the first cycle with pe_stage_1_valid=1 (WAIT_S1) or pe_stage_2_valid=1 (WAIT_S2), the matching store_temp strobe SHALL assert combinationally that cycle; pc+1; go to FETCH.
REQ-013 WAIT_RES: on pe_stage_2_valid=1, store_result SHALL assert that cycle; pc+1; go to FETCH.
REQ-014 A valid already high on the first wait cycle SHALL complete the wait in that cycle.
REQ-015 A wait counter SHALL clear on wait entry; reaching WAIT_TIMEOUT cycles without valid SHALL go to ERR with err_code=2.
REQ-016 STOP SHALL go to HALT: done=1, busy=0, pc held.
REQ-017 An illegal opcode SHALL go to ERR with err_code=1.
REQ-018 A non-STOP instruction completing at pc=IRAM_DEPTH-1 SHALL go to ERR with err_code=3; pc SHALL never wrap.
REQ-019 ERR SHALL hold err=1, busy=0 until rst; start SHALL be ignored in ERR.
REQ-020 busy SHALL be 1 in FETCH, DECODE and all WAIT states, else 0; done SHALL be 1 only in HALT.

Reset
REQ-021 rst=1 at a clk edge, in any state including mid-wait, SHALL force IDLE, pc=0, wait counter=0, res_addr=0, err_code=0, and all strobes/status outputs 0.
REQ-022 rst SHALL take priority over start and step in the same cycle.

Structure
REQ-023 The opcode enum, PE op-code enum, err_code enum and width constants SHALL live in the shared package pe_pkg.
REQ-024 The block SHALL be a single module; no sub-module is required.

Verification
REQ-025 Program NOOP, FETCH_A@0x12, FETCH_B@0x34, ADD, STOP; start -> dmem_a_rd with addr 0x12 at cycle 4; dmem_b_rd with 0x34 at cycle 6; pe_issue with op 1 at cycle 8; done at cycle 11.
REQ-026 STORE_RESULT@0x55 with pe_stage_2_valid raised 5 cycles later -> single store_result pulse, res_addr=0x55, pc advances.
REQ-027 STORE_TEMP_S1 with pe_stage_1_valid never raised -> ERR, err_code=2 after 64 wait cycles; no store_temp_s1.
REQ-028 Opcode 13 at pc=3 -> ERR with err_code=1, pc=3; start then ignored; rst returns to IDLE.
REQ-029 step_en=1 -> FETCH holds without step; each step pulse advances exactly one instruction.
REQ-030 rst asserted during WAIT_RES -> next cycle IDLE, all outputs 0; IRAM filled with NOOP -> err_code=3 at pc=255.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the PE sequencer.
//   - Port widths for addresses, opcodes, PE op-codes and error codes.
//   - Instruction opcode enum (instruction bits [3:0]).
//   - PE operation code enum driven on pe_opcode.
//   - Error code enum reported on err_code.
//   - Sequencer state enum.
package pe_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned PE_OP_W = 3;
  localparam int unsigned ERR_W   = 2;

  typedef enum logic [OPC_W-1:0] {
    OP_NOOP          = 4'd0,
    OP_FETCH_A       = 4'd1,
    OP_FETCH_B       = 4'd2,
    OP_ADD           = 4'd3,
    OP_SUB           = 4'd4,
    OP_MUL           = 4'd5,
    OP_DOTP          = 4'd6,
    OP_STORE_TEMP_S1 = 4'd7,
    OP_STORE_TEMP_S2 = 4'd8,
    OP_STORE_RESULT  = 4'd9,
    OP_STOP          = 4'd10
  } opcode_e;

  typedef enum logic [PE_OP_W-1:0] {
    PE_NONE = 3'd0,
    PE_ADD  = 3'd1,
    PE_SUB  = 3'd2,
    PE_MUL  = 3'd3,
    PE_DOTP = 3'd4
  } pe_op_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_WAIT_S1  = 3'd3,
    ST_WAIT_S2  = 3'd4,
    ST_WAIT_RES = 3'd5,
    ST_HALT     = 3'd6,
    ST_ERR      = 3'd7
  } state_e;

endpackage

// File: rtl/pe_seq_controller.sv
// PE sequencer: fetches 16-bit instructions from an external IRAM, issues
// operand reads, PE operations and store strobes, and waits on PE stage
// valids for the store instructions.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    run pulse (honoured in IDLE/HALT only)
//   step_en, step            single-step mode and step pulse
//   imem_addr / imem_rdata   instruction address / data (data one cycle later)
//   dmem_a_rd, dmem_a_addr   operand-A read strobe and address
//   dmem_b_rd, dmem_b_addr   operand-B read strobe and address
//   pe_issue, pe_opcode      PE operation strobe and code
//   pe_stage_1_valid/_2_     PE stage results ready
//   store_temp_s1/_s2        temp-store strobes
//   store_result, res_addr   result-store strobe and latched address
//   busy, done, err          status
//   err_code                 1 illegal opcode, 2 wait timeout, 3 pc overrun
//   pc                       current program counter
module pe_seq_controller
  import pe_pkg::*;
#(
  parameter int unsigned INST_W       = 16,
  parameter int unsigned DATA_LEN     = 32,
  parameter int unsigned IRAM_DEPTH   = 256,
  parameter int unsigned DRAM_DEPTH   = 256,
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step_en,
  input  logic               step,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INST_W-1:0]  imem_rdata,
  output logic               dmem_a_rd,
  output logic [ADDR_W-1:0]  dmem_a_addr,
  output logic               dmem_b_rd,
  output logic [ADDR_W-1:0]  dmem_b_addr,
  output logic               pe_issue,
  output logic [PE_OP_W-1:0] pe_opcode,
  input  logic               pe_stage_1_valid,
  input  logic               pe_stage_2_valid,
  output logic               store_temp_s1,
  output logic               store_temp_s2,
  output logic               store_result,
  output logic [ADDR_W-1:0]  res_addr,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ERR_W-1:0]   err_code,
  output logic [ADDR_W-1:0]  pc
);

  localparam int unsigned       WCNT_W    = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(IRAM_DEPTH - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_TIMEOUT - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   res_addr_q;
  logic [WCNT_W-1:0]   wcnt_q;
  err_code_e           err_q;

  opcode_e             opc;
  logic [ADDR_W-1:0]   operand;
  pe_op_e              pe_op;
  logic                instr_done;

  assign opc     = opcode_e'(imem_rdata[OPC_W-1:0]);
  assign operand = imem_rdata[OPC_W +: ADDR_W];

  // Reserved instruction bits and the data-path sizing parameters have no
  // effect on sequencing.
  logic unused_inputs;
  assign unused_inputs = ^{imem_rdata[INST_W-1:OPC_W+ADDR_W],
                           1'(DATA_LEN), 1'(DRAM_DEPTH)};

  // Strobes are decoded from the current state and instruction so they are
  // high in exactly the decode / wait-completion cycle. instr_done marks the
  // cycle in which an instruction that advances pc finishes.
  always_comb begin
    dmem_a_rd     = 1'b0;
    dmem_a_addr   = '0;
    dmem_b_rd     = 1'b0;
    dmem_b_addr   = '0;
    pe_issue      = 1'b0;
    pe_op         = PE_NONE;
    store_temp_s1 = 1'b0;
    store_temp_s2 = 1'b0;
    store_result  = 1'b0;
    instr_done    = 1'b0;
    case (state_q)
      ST_DECODE: begin
        case (opc)
          OP_NOOP: instr_done = 1'b1;
          OP_FETCH_A: begin
            dmem_a_rd   = 1'b1;
            dmem_a_addr = operand;
            instr_done  = 1'b1;
          end
          OP_FETCH_B: begin
            dmem_b_rd   = 1'b1;
            dmem_b_addr = operand;
            instr_done  = 1'b1;
          end
          OP_ADD: begin
            pe_issue   = 1'b1;
            pe_op      = PE_ADD;
            instr_done = 1'b1;
          end
          OP_SUB: begin
            pe_issue   = 1'b1;
            pe_op      = PE_SUB;
            instr_done = 1'b1;
          end
          OP_MUL: begin
            pe_issue   = 1'b1;
            pe_op      = PE_MUL;
            instr_done = 1'b1;
          end
          OP_DOTP: begin
            pe_issue   = 1'b1;
            pe_op      = PE_DOTP;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      ST_WAIT_S1: begin
        store_temp_s1 = pe_stage_1_valid;
        instr_done    = pe_stage_1_valid;
      end
      ST_WAIT_S2: begin
        store_temp_s2 = pe_stage_2_valid;
        instr_done    = pe_stage_2_valid;
      end
      ST_WAIT_RES: begin
        store_result = pe_stage_2_valid;
        instr_done   = pe_stage_2_valid;
      end
      default: ;
    endcase
  end

  assign pe_opcode = pe_op;

  // Every pc-advancing completion (decode of a simple op or a wait that saw
  // its valid) shares one path, so the overrun check lives in one place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      wcnt_q     <= '0;
      res_addr_q <= '0;
      err_q      <= ERR_NONE;
    end else if (instr_done) begin
      if (pc_q == LAST_PC) begin
        state_q <= ST_ERR;
        err_q   <= ERR_OVERRUN;
      end else begin
        pc_q    <= pc_q + 1'b1;
        state_q <= ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            pc_q    <= '0;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!step_en || step) state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          case (opc)
            OP_STORE_TEMP_S1: begin
              wcnt_q  <= '0;
              state_q <= ST_WAIT_S1;
            end
            OP_STORE_TEMP_S2: begin
              wcnt_q  <= '0;
              state_q <= ST_WAIT_S2;
            end
            OP_STORE_RESULT: begin
              wcnt_q     <= '0;
              res_addr_q <= operand;
              state_q    <= ST_WAIT_RES;
            end
            OP_STOP: state_q <= ST_HALT;
            OP_NOOP, OP_FETCH_A, OP_FETCH_B,
            OP_ADD, OP_SUB, OP_MUL, OP_DOTP: ;
            default: begin
              state_q <= ST_ERR;
              err_q   <= ERR_ILLEGAL;
            end
          endcase
        end
        ST_WAIT_S1, ST_WAIT_S2, ST_WAIT_RES: begin
          // wcnt_q counts completed wait cycles without a valid.
          if (wcnt_q == WAIT_LAST) begin
            state_q <= ST_ERR;
            err_q   <= ERR_TIMEOUT;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        default: ;  // ST_ERR holds until reset
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign res_addr  = res_addr_q;
  assign err_code  = err_q;
  assign busy      = (state_q == ST_FETCH)   || (state_q == ST_DECODE)  ||
                     (state_q == ST_WAIT_S1) || (state_q == ST_WAIT_S2) ||
                     (state_q == ST_WAIT_RES);
  assign done      = (state_q == ST_HALT);
  assign err       = (state_q == ST_ERR);

endmodule
